unidade_controle_rodadas: RTL and testbench

Parametrised control unit for the memory-sequence game, successor to the fixed single-pass controller. It plays rounds of growing length: round k requires k+1 correct plays. It owns a round counter and an optional per-play timeout counter, and drives the external datapath (address counter, play register, comparator) through Moore outputs. It sits between the top-level wrapper and the existing datapath.

---
 rtl/jogo_pkg.sv | 27 ++
 rtl/unidade_controle_rodadas_if.sv | 33 +++
 rtl/contador_timeout.sv | 30 +++
 rtl/unidade_controle_rodadas.sv | 146 ++++++++++++++
 tb/tb_unidade_controle_rodadas.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-sequence game control unit:
// 4-bit state codes shown on the debug display, the code shown for an
// illegal state, and the lower bounds accepted for the unit's parameters.
package jogo_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIO_RODADA  = 4'h2,
        ESPERA         = 4'h3,
        REGISTRA       = 4'h4,
        COMPARA        = 4'h5,
        PROXIMA        = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FINAL_ACERTO   = 4'h8,
        FINAL_ERRO     = 4'h9,
        FINAL_TIMEOUT  = 4'hA
    } estado_t;

    // Debug code displayed while the state register holds an unused encoding
    localparam logic [3:0] DB_ILEGAL = 4'hF;

    // Smallest legal values for the round count and the per-play timeout
    localparam int MIN_RODADAS = 2;
    localparam int MIN_TIMEOUT = 2;

endpackage

// File: rtl/unidade_controle_rodadas_if.sv
// Signal bundle between the round control unit and its environment
// (top-level wrapper inputs plus datapath control outputs).
// master: the side driving iniciar/jogada/igual/fimE; slave: the control unit.
interface unidade_controle_rodadas_if #(
    parameter int W_RODADA = 4
);
    logic                iniciar;
    logic                jogada;
    logic                igual;
    logic                fimE;
    logic                zeraE;
    logic                contaE;
    logic                zeraR;
    logic                registraR;
    logic [W_RODADA-1:0] rodada;
    logic                acertou;
    logic                errou;
    logic                timeout;
    logic                pronto;
    logic [3:0]          db_estado;

    modport master (
        output iniciar, jogada, igual, fimE,
        input  zeraE, contaE, zeraR, registraR, rodada,
        input  acertou, errou, timeout, pronto, db_estado
    );

    modport slave (
        input  iniciar, jogada, igual, fimE,
        output zeraE, contaE, zeraR, registraR, rodada,
        output acertou, errou, timeout, pronto, db_estado
    );
endinterface

// File: rtl/contador_timeout.sv
// Per-play timer: counts cycles while conta is high and raises fim once the
// count reaches MAX-1. It holds there instead of wrapping so a late play
// can never make the timeout disappear. zera has priority over conta.
module contador_timeout #(
    parameter int MAX = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);
    localparam int W = (MAX > 1) ? $clog2(MAX) : 1;

    logic [W-1:0] contagem_reg;

    // Saturating up-counter with synchronous clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem_reg <= '0;
        end else if (zera) begin
            contagem_reg <= '0;
        end else if (conta && !fim) begin
            contagem_reg <= contagem_reg + 1'b1;
        end
    end

    assign fim = (contagem_reg == W'(MAX - 1));

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Round-based control unit for the memory-sequence game. Round k needs k+1
// correct plays; the unit steers the external address counter, play
// register and comparator through Moore outputs decoded from the state.
// Optional feature macro: UC_TIMEOUT_EN builds the per-play timer and the
// final_timeout state; without it espera waits forever and timeout is 0.
module unidade_controle_rodadas
    import jogo_pkg::*;
#(
    parameter int N_RODADAS      = 16,
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int W_RODADA       = $clog2(N_RODADAS)
) (
    input  logic                        clock,
    input  logic                        reset,
    unidade_controle_rodadas_if.slave   bus
);

    if (N_RODADAS < MIN_RODADAS) begin : g_erro_rodadas
        $error("N_RODADAS must be at least %0d", MIN_RODADAS);
    end
    if (TIMEOUT_CICLOS < MIN_TIMEOUT) begin : g_erro_timeout
        $error("TIMEOUT_CICLOS must be at least %0d", MIN_TIMEOUT);
    end

    localparam logic [W_RODADA-1:0] ULTIMA_RODADA = W_RODADA'(N_RODADAS - 1);

    estado_t             state_reg, state_next;
    logic [W_RODADA-1:0] rodada_reg, rodada_next;

`ifdef UC_TIMEOUT_EN
    logic fim_timer;

    // Timer runs only while waiting for a play and restarts on every other state
    contador_timeout #(
        .MAX (TIMEOUT_CICLOS)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .zera  (state_reg != ESPERA),
        .conta (state_reg == ESPERA),
        .fim   (fim_timer)
    );
`endif

    // State and round registers; reset aborts a game at once
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= INICIAL;
            rodada_reg <= '0;
        end else begin
            state_reg  <= state_next;
            rodada_reg <= rodada_next;
        end
    end

    // Round index: cleared while preparing, advanced (never past the last) between rounds
    always_comb begin
        rodada_next = rodada_reg;
        if (state_reg == PREPARACAO) begin
            rodada_next = '0;
        end else if (state_reg == PROXIMA_RODADA && rodada_reg != ULTIMA_RODADA) begin
            rodada_next = rodada_reg + 1'b1;
        end
    end

    // Next-state logic; jogada only matters in espera, where it beats the timer
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INICIAL:        if (bus.iniciar) state_next = PREPARACAO;
            PREPARACAO:     state_next = INICIO_RODADA;
            INICIO_RODADA:  state_next = ESPERA;
            ESPERA: begin
                if (bus.jogada) begin
                    state_next = REGISTRA;
                end
`ifdef UC_TIMEOUT_EN
                else if (fim_timer) begin
                    state_next = FINAL_TIMEOUT;
                end
`endif
            end
            REGISTRA:       state_next = COMPARA;
            COMPARA: begin
                if (!bus.igual) begin
                    state_next = FINAL_ERRO;
                end else if (!bus.fimE) begin
                    state_next = PROXIMA;
                end else if (rodada_reg == ULTIMA_RODADA) begin
                    state_next = FINAL_ACERTO;
                end else begin
                    state_next = PROXIMA_RODADA;
                end
            end
            PROXIMA:        state_next = ESPERA;
            PROXIMA_RODADA: state_next = INICIO_RODADA;
            FINAL_ACERTO,
            FINAL_ERRO:     if (bus.iniciar) state_next = PREPARACAO;
`ifdef UC_TIMEOUT_EN
            FINAL_TIMEOUT:  if (bus.iniciar) state_next = PREPARACAO;
`endif
            default:        state_next = INICIAL;
        endcase
    end

    // Moore outputs decoded from the current state only
    always_comb begin
        bus.zeraE     = 1'b0;
        bus.contaE    = 1'b0;
        bus.zeraR     = 1'b0;
        bus.registraR = 1'b0;
        bus.acertou   = 1'b0;
        bus.errou     = 1'b0;
        bus.timeout   = 1'b0;
        bus.pronto    = 1'b0;
        bus.db_estado = state_reg;
        case (state_reg)
            INICIAL, PREPARACAO: begin
                bus.zeraE = 1'b1;
                bus.zeraR = 1'b1;
            end
            INICIO_RODADA:  bus.zeraE     = 1'b1;
            REGISTRA:       bus.registraR = 1'b1;
            PROXIMA:        bus.contaE    = 1'b1;
            ESPERA, COMPARA, PROXIMA_RODADA: ;
            FINAL_ACERTO: begin
                bus.pronto  = 1'b1;
                bus.acertou = 1'b1;
            end
            FINAL_ERRO: begin
                bus.pronto = 1'b1;
                bus.errou  = 1'b1;
            end
`ifdef UC_TIMEOUT_EN
            FINAL_TIMEOUT: begin
                bus.pronto  = 1'b1;
                bus.timeout = 1'b1;
            end
`endif
            default:        bus.db_estado = DB_ILEGAL;
        endcase
    end

    assign bus.rodada = rodada_reg;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Self-checking bench for unidade_controle_rodadas (N_RODADAS=4,
// TIMEOUT_CICLOS=10). Games are planned per play (correct/wrong, idle delay,
// optional reset abort); a game-level model predicts the verdict and final
// round, and every cycle is checked against the state sequence of the rules.
module tb_unidade_controle_rodadas;

    localparam int N    = 4;
    localparam int T    = 10;
    localparam int W    = 2;
    localparam int MAXP = N * (N + 1) / 2;

`ifdef UC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    unidade_controle_rodadas_if #(.W_RODADA(W)) bus ();

    unidade_controle_rodadas #(
        .N_RODADAS      (N),
        .TIMEOUT_CICLOS (T),
        .W_RODADA       (W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int prev_rod = 0;

    bit p_igual [MAXP];
    int p_delay [MAXP];
    int abort_play;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Output table: {zeraE, contaE, zeraR, registraR, acertou, errou, timeout, pronto}
    function automatic logic [7:0] outs_for(input int code);
        case (code)
            0, 1:    return 8'b1010_0000;
            2:       return 8'b1000_0000;
            4:       return 8'b0001_0000;
            6:       return 8'b0100_0000;
            8:       return 8'b0000_1001;
            9:       return 8'b0000_0101;
            10:      return 8'b0000_0011;
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic expect_state(input string tag, input int code, input int rod);
        logic [7:0] outs;
        outs = {bus.zeraE, bus.contaE, bus.zeraR, bus.registraR,
                bus.acertou, bus.errou, bus.timeout, bus.pronto};
        check_val({tag, ".db_estado"}, 32'(bus.db_estado), 32'(code));
        check_val({tag, ".outs"}, 32'(outs), 32'(outs_for(code)));
        check_val({tag, ".rodada"}, 32'(bus.rodada), 32'(rod));
    endtask

    // Game-level prediction: 0 acerto, 1 erro, 2 timeout, 3 aborted by reset
    function automatic void predict(output int outcome, output int last_round, output int n_plays);
        int p;
        p = 0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j <= k; j++) begin
                if (TO_EN && p_delay[p] >= T) begin
                    outcome = 2; last_round = k; n_plays = p; return;
                end
                if (p == abort_play) begin
                    outcome = 3; last_round = 0; n_plays = p + 1; return;
                end
                if (!p_igual[p]) begin
                    outcome = 1; last_round = k; n_plays = p + 1; return;
                end
                p++;
            end
        end
        outcome = 0; last_round = N - 1; n_plays = p;
    endfunction

    task automatic plan_clean();
        for (int i = 0; i < MAXP; i++) begin
            p_igual[i] = 1'b1;
            p_delay[i] = 0;
        end
        abort_play = -1;
    endtask

    task automatic plan_random();
        for (int i = 0; i < MAXP; i++) begin
            p_igual[i] = ($urandom_range(0, 15) != 0);
            p_delay[i] = ($urandom_range(0, 19) == 0) ? int'($urandom_range(T - 1, T + 2))
                                                       : int'($urandom_range(0, 3));
        end
        abort_play = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, MAXP - 1)) : -1;
    endtask

    task automatic run_game(input int g);
        int  exp_out, exp_round, exp_plays, code;
        int  k, j, p, plays;
        bit  done, aborted;
        predict(exp_out, exp_round, exp_plays);
        k = 0; j = 0; p = 0; plays = 0; done = 1'b0; aborted = 1'b0;

        bus.iniciar = 1'b1; bus.jogada = rnd(); step();
        expect_state("prep", 1, prev_rod);
        bus.iniciar = rnd(); bus.jogada = rnd(); step();
        expect_state("inicio", 2, 0);
        bus.jogada = rnd(); step();
        expect_state("espera", 3, 0);

        while (!done) begin
            for (int i = 0; i < p_delay[p]; i++) begin
                bus.jogada = 1'b0; bus.igual = rnd(); bus.fimE = rnd(); bus.iniciar = rnd();
                step();
                if (TO_EN && i == T - 1) begin
                    expect_state("timeout", 10, k);
                    done = 1'b1;
                    break;
                end
                expect_state("idle", 3, k);
            end
            if (done) break;

            plays++;
            bus.jogada = 1'b1; bus.igual = p_igual[p]; bus.fimE = (j == k);
            step();
            expect_state("registra", 4, k);
            bus.jogada = rnd(); step();
            expect_state("compara", 5, k);

            if (p == abort_play) begin
                #2 reset = 1'b0;
                #1 expect_state("abort", 0, 0);
                bus.iniciar = 1'b0; bus.jogada = 1'b0;
                #2 reset = 1'b1;
                step();
                expect_state("pos_abort", 0, 0);
                aborted = 1'b1;
                done = 1'b1;
                break;
            end

            bus.jogada = rnd(); step();
            if (!p_igual[p]) begin
                expect_state("erro", 9, k);
                done = 1'b1;
            end else if (j < k) begin
                expect_state("proxima", 6, k);
                bus.jogada = rnd(); bus.igual = rnd(); bus.fimE = rnd(); step();
                expect_state("volta_espera", 3, k);
                j++; p++;
            end else if (k == N - 1) begin
                expect_state("acerto", 8, k);
                done = 1'b1;
            end else begin
                expect_state("prox_rodada", 7, k);
                bus.jogada = rnd(); step();
                expect_state("nova_rodada", 2, k + 1);
                bus.jogada = rnd(); step();
                expect_state("espera_rodada", 3, k + 1);
                k++; j = 0; p++;
            end
        end

        code = (exp_out == 0) ? 8 : (exp_out == 1) ? 9 : (exp_out == 2) ? 10 : 0;
        check_val("verdict", 32'(bus.db_estado), 32'(code));
        check_val("verdict_rodada", 32'(bus.rodada), 32'(exp_round));
        check_val("verdict_plays", 32'(plays), 32'(exp_plays));
        if (!aborted) begin
            bus.iniciar = 1'b0; bus.jogada = rnd(); step();
            expect_state("hold", code, exp_round);
        end
        prev_rod = exp_round;
        $display("game %0d: plays=%0d outcome=%0d db_estado=%0h rodada=%0d",
                 g, plays, exp_out, bus.db_estado, bus.rodada);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iniciar = 1'b0; bus.jogada = 1'b0; bus.igual = 1'b0; bus.fimE = 1'b0;
        reset = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        expect_state("reset_low", 0, 0);
        #2 reset = 1'b1;
        step();
        expect_state("reset_idle", 0, 0);
        bus.jogada = 1'b1; step();
        expect_state("reset_idle2", 0, 0);

        for (int g = 0; g < 30; g++) begin
            plan_clean();
            case (g)
                0: ;                                           // full correct game
                1: begin p_igual[4] = 1'b0; p_delay[2] = 2; end // wrong 2nd play of round 2
                2: p_delay[0] = 100;                           // long idle: timeout or keep waiting
                3: p_delay[0] = T - 1;                         // play on the last allowed cycle
                4: abort_play = 4;                             // reset during compara in round 2
                default: plan_random();
            endcase
            run_game(g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
